// File: rtl/mem_axi_arb.sv
// Arbitrates NUM_CH AXI4 gmem masters onto one TSIM memory port, one whole burst at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_axi_arb #(
    parameter int NUM_CH        = 2,
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst_n,
    input  logic [NUM_CH-1:0]                 m_axi_gmem_ARVALID,
    output logic [NUM_CH-1:0]                 m_axi_gmem_ARREADY,
    input  logic [NUM_CH*MEM_ADDR_BITS-1:0]   m_axi_gmem_ARADDR,
    input  logic [NUM_CH*8-1:0]               m_axi_gmem_ARLEN,
    output logic [NUM_CH-1:0]                 m_axi_gmem_RVALID,
    input  logic [NUM_CH-1:0]                 m_axi_gmem_RREADY,
    output logic [MEM_DATA_BITS-1:0]          m_axi_gmem_RDATA,
    output logic [NUM_CH-1:0]                 m_axi_gmem_RLAST,
    output logic [1:0]                        m_axi_gmem_RRESP,
    input  logic [NUM_CH-1:0]                 m_axi_gmem_AWVALID,
    output logic [NUM_CH-1:0]                 m_axi_gmem_AWREADY,
    input  logic [NUM_CH*MEM_ADDR_BITS-1:0]   m_axi_gmem_AWADDR,
    input  logic [NUM_CH*8-1:0]               m_axi_gmem_AWLEN,
    input  logic [NUM_CH-1:0]                 m_axi_gmem_WVALID,
    output logic [NUM_CH-1:0]                 m_axi_gmem_WREADY,
    input  logic [NUM_CH-1:0]                 m_axi_gmem_WLAST,
    input  logic [NUM_CH*MEM_DATA_BITS-1:0]   m_axi_gmem_WDATA,
    output logic [NUM_CH-1:0]                 m_axi_gmem_BVALID,
    input  logic [NUM_CH-1:0]                 m_axi_gmem_BREADY,
    output logic [1:0]                        m_axi_gmem_BRESP,
    output logic                              mem_req_valid,
    output logic                              mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]           mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]          mem_req_addr,
    output logic                              mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]          mem_wr_bits,
    input  logic                              mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]          mem_rd_bits,
    output logic                              mem_rd_ready,
    output logic [2:0]                        dbg_state
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    generate
        if (MEM_LEN_BITS < 8) begin : g_len_chk
            $error("mem_axi_arb: MEM_LEN_BITS must be >= 8");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_ch_chk
            $error("mem_axi_arb: NUM_CH must be in 1..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [CH_W-1:0]            gnt_q;
    logic                       op_q;
    logic [7:0]                 len_q;
    logic [MEM_ADDR_BITS-1:0]   addr_q;
    logic [7:0]                 cnt_q;
    logic                       err_q;
    logic [NUM_CH-1:0]          next_wr_q;

    logic [NUM_CH-1:0]          req;
    logic                       gnt_any;
    logic [CH_W-1:0]            gnt_idx;
    logic                       gnt_wr;
    logic                       grant;
    logic                       last_beat;
    logic                       rd_beat;
    logic                       wr_beat;

    assign req = m_axi_gmem_ARVALID | m_axi_gmem_AWVALID;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end
`else
    logic [CH_W-1:0] rr_q;
    int              idx;

    // Scan channels starting at rr_q; the first requester found wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_q <= '0;
        end else if (grant) begin
            rr_q <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    // With both AR and AW pending, alternate against the channel's previous op (read first).
    assign gnt_wr    = m_axi_gmem_AWVALID[gnt_idx] &
                       (~m_axi_gmem_ARVALID[gnt_idx] | next_wr_q[gnt_idx]);
    assign grant     = ap_rst_n & (state_q == S_IDLE) & gnt_any;
    assign last_beat = (cnt_q == len_q);
    assign rd_beat   = (state_q == S_RD) & mem_rd_valid & m_axi_gmem_RREADY[gnt_q];
    assign wr_beat   = (state_q == S_WR) & m_axi_gmem_WVALID[gnt_q];
    assign dbg_state = state_q;
    assign m_axi_gmem_RRESP = 2'b00;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            op_q      <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            next_wr_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_q              <= gnt_idx;
                op_q               <= gnt_wr;
                len_q              <= gnt_wr ? m_axi_gmem_AWLEN[gnt_idx*8 +: 8]
                                             : m_axi_gmem_ARLEN[gnt_idx*8 +: 8];
                addr_q             <= gnt_wr ? m_axi_gmem_AWADDR[gnt_idx*MEM_ADDR_BITS +: MEM_ADDR_BITS]
                                             : m_axi_gmem_ARADDR[gnt_idx*MEM_ADDR_BITS +: MEM_ADDR_BITS];
                cnt_q              <= '0;
                err_q              <= 1'b0;
                next_wr_q[gnt_idx] <= ~gnt_wr;
            end
            if (rd_beat || wr_beat) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (wr_beat && (m_axi_gmem_WLAST[gnt_q] != last_beat)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Every channel handshake is plain AXI valid/ready: a beat transfers on a cycle where
    // both are high; only the granted channel ever sees a non-zero READY/VALID output.
    always_comb begin
        state_d            = state_q;
        m_axi_gmem_ARREADY = '0;
        m_axi_gmem_AWREADY = '0;
        m_axi_gmem_RVALID  = '0;
        m_axi_gmem_RLAST   = '0;
        m_axi_gmem_RDATA   = '0;
        m_axi_gmem_WREADY  = '0;
        m_axi_gmem_BVALID  = '0;
        m_axi_gmem_BRESP   = 2'b00;
        mem_req_valid      = 1'b0;
        mem_req_opcode     = 1'b0;
        mem_req_len        = '0;
        mem_req_addr       = '0;
        mem_wr_valid       = 1'b0;
        mem_wr_bits        = '0;
        mem_rd_ready       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    m_axi_gmem_ARREADY[gnt_idx] = ~gnt_wr;
                    m_axi_gmem_AWREADY[gnt_idx] = gnt_wr;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid  = 1'b1;
                mem_req_opcode = op_q;
                mem_req_len    = MEM_LEN_BITS'(len_q);
                mem_req_addr   = addr_q;
                state_d        = op_q ? S_WR : S_RD;
            end
            S_RD: begin
                m_axi_gmem_RVALID[gnt_q] = mem_rd_valid;
                m_axi_gmem_RLAST[gnt_q]  = mem_rd_valid & last_beat;
                m_axi_gmem_RDATA         = mem_rd_bits;
                mem_rd_ready             = m_axi_gmem_RREADY[gnt_q];
                if (rd_beat && last_beat) state_d = S_IDLE;
            end
            S_WR: begin
                m_axi_gmem_WREADY[gnt_q] = 1'b1;
                mem_wr_valid             = m_axi_gmem_WVALID[gnt_q];
                mem_wr_bits              = m_axi_gmem_WDATA[gnt_q*MEM_DATA_BITS +: MEM_DATA_BITS];
                if (wr_beat && last_beat) state_d = S_RESP;
            end
            S_RESP: begin
                m_axi_gmem_BVALID[gnt_q] = 1'b1;
                m_axi_gmem_BRESP         = err_q ? 2'b10 : 2'b00;
                if (m_axi_gmem_BREADY[gnt_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_axi_arb.sv
// Directed bench for mem_axi_arb with two channels; expectations are hand-computed per step.
module tb_mem_axi_arb;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [1:0]    arvalid, arready, rvalid, rready, rlast;
    logic [63:0]   araddr, awaddr;
    logic [15:0]   arlen, awlen;
    logic [63:0]   rdata;
    logic [1:0]    rresp, bresp;
    logic [1:0]    awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [127:0]  wdata;
    logic          mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_valid, mem_rd_ready;
    logic [7:0]    mem_req_len;
    logic [31:0]   mem_req_addr;
    logic [63:0]   mem_wr_bits, mem_rd_bits;
    logic [2:0]    dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 ap_clk = ~ap_clk;

    mem_axi_arb #(
        .NUM_CH(2), .MEM_LEN_BITS(8), .MEM_ADDR_BITS(32), .MEM_DATA_BITS(64)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .m_axi_gmem_ARVALID(arvalid), .m_axi_gmem_ARREADY(arready),
        .m_axi_gmem_ARADDR(araddr), .m_axi_gmem_ARLEN(arlen),
        .m_axi_gmem_RVALID(rvalid), .m_axi_gmem_RREADY(rready),
        .m_axi_gmem_RDATA(rdata), .m_axi_gmem_RLAST(rlast), .m_axi_gmem_RRESP(rresp),
        .m_axi_gmem_AWVALID(awvalid), .m_axi_gmem_AWREADY(awready),
        .m_axi_gmem_AWADDR(awaddr), .m_axi_gmem_AWLEN(awlen),
        .m_axi_gmem_WVALID(wvalid), .m_axi_gmem_WREADY(wready),
        .m_axi_gmem_WLAST(wlast), .m_axi_gmem_WDATA(wdata),
        .m_axi_gmem_BVALID(bvalid), .m_axi_gmem_BREADY(bready), .m_axi_gmem_BRESP(bresp),
        .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
        .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
        .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
        .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen one unit later.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] exp_oh;
    int         exp_g;

    initial begin
        arvalid = '0; araddr = '0; arlen = '0; rready = '0;
        awvalid = '0; awaddr = '0; awlen = '0;
        wvalid = '0; wlast = '0; wdata = '0; bready = '0;
        mem_rd_valid = 1'b0; mem_rd_bits = '0;

        // Reset: a pending request must not be accepted while reset is held
        arvalid = 2'b01; araddr[31:0] = 32'h1000; arlen[7:0] = 8'd3;
        tick(); tick(); settle();
        chk("rst_arready", arready, 2'b00);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_bvalid", bvalid, 2'b00);

        // Test 1: ch0 read, 4 beats
        ap_rst_n = 1'b1; settle();
        chk("t1_arready", arready, 2'b01);
        chk("t1_awready", awready, 2'b00);
        tick(); arvalid = '0; settle();
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_req_op", mem_req_opcode, 0);
        chk("t1_req_len", mem_req_len, 3);
        chk("t1_req_addr", mem_req_addr, 32'h1000);
        chk("t1_arready_off", arready, 2'b00);
        tick(); mem_rd_valid = 1'b1; rready = 2'b01;
        for (int b = 0; b < 4; b++) begin
            mem_rd_bits = 64'hD000 + 64'(b); settle();
            chk("t1_rvalid", rvalid, 2'b01);
            chk("t1_rdata", rdata, 64'hD000 + 64'(b));
            chk("t1_rlast", rlast, (b == 3) ? 2'b01 : 2'b00);
            chk("t1_rd_ready", mem_rd_ready, 1);
            tick();
        end
        mem_rd_valid = 1'b0; rready = '0; settle();
        chk("t1_idle", dbg_state, 0);
        chk("t1_rvalid_off", rvalid, 2'b00);

        // Test 2: ch0 write, 2 beats, clean response held until BREADY
        awvalid = 2'b01; awaddr[31:0] = 32'h2000; awlen[7:0] = 8'd1; settle();
        chk("t2_awready", awready, 2'b01);
        chk("t2_arready", arready, 2'b00);
        tick(); awvalid = '0; settle();
        chk("t2_req_valid", mem_req_valid, 1);
        chk("t2_req_op", mem_req_opcode, 1);
        chk("t2_req_len", mem_req_len, 1);
        chk("t2_req_addr", mem_req_addr, 32'h2000);
        tick(); wvalid = 2'b01;
        for (int b = 0; b < 2; b++) begin
            wdata[63:0] = 64'hA0 + 64'(b); wlast = (b == 1) ? 2'b01 : 2'b00; settle();
            chk("t2_wready", wready, 2'b01);
            chk("t2_wr_valid", mem_wr_valid, 1);
            chk("t2_wr_bits", mem_wr_bits, 64'hA0 + 64'(b));
            tick();
        end
        wvalid = '0; wlast = '0; settle();
        chk("t2_bvalid", bvalid, 2'b01);
        chk("t2_bresp", bresp, 2'b00);
        chk("t2_wr_valid_off", mem_wr_valid, 0);
        tick(); settle();
        chk("t2_bvalid_held", bvalid, 2'b01);
        bready = 2'b01; tick(); bready = '0; settle();
        chk("t2_bvalid_off", bvalid, 2'b00);
        chk("t2_idle", dbg_state, 0);

        // Test 3: both channels read continuously; rr pointer starts from reset
        ap_rst_n = 1'b0; tick(); ap_rst_n = 1'b1;
        araddr = {32'h3100, 32'h3000}; arlen = '0; arvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % 2;
`endif
            exp_oh = (exp_g == 1) ? 2'b10 : 2'b01;
            settle();
            chk("t3_arready", arready, exp_oh);
            tick(); settle();
            chk("t3_req_addr", mem_req_addr, (exp_g == 1) ? 32'h3100 : 32'h3000);
            tick(); mem_rd_valid = 1'b1; rready = 2'b11; mem_rd_bits = 64'hE0 + 64'(k); settle();
            chk("t3_rvalid", rvalid, exp_oh);
            chk("t3_rlast", rlast, exp_oh);
            tick(); mem_rd_valid = 1'b0; rready = '0;
        end
        arvalid = '0;

        // Test 4: ch1 write len=2 with early WLAST -> all 3 beats written, SLVERR
        awvalid = 2'b10; awaddr[63:32] = 32'h4000; awlen[15:8] = 8'd2; settle();
        chk("t4_awready", awready, 2'b10);
        tick(); awvalid = '0; settle();
        chk("t4_req_op", mem_req_opcode, 1);
        chk("t4_req_len", mem_req_len, 2);
        chk("t4_req_addr", mem_req_addr, 32'h4000);
        tick(); wvalid = 2'b11; wdata[63:0] = 64'hDEAD;
        for (int b = 0; b < 3; b++) begin
            wdata[127:64] = 64'hB0 + 64'(b); wlast = (b == 1) ? 2'b10 : 2'b00; settle();
            chk("t4_wready", wready, 2'b10);
            chk("t4_wr_valid", mem_wr_valid, 1);
            chk("t4_wr_bits", mem_wr_bits, 64'hB0 + 64'(b));
            tick();
        end
        wvalid = '0; wlast = '0; settle();
        chk("t4_bvalid", bvalid, 2'b10);
        chk("t4_bresp", bresp, 2'b10);
        bready = 2'b10; tick(); bready = '0; settle();
        chk("t4_idle", dbg_state, 0);

        // Per-channel toggle: ch0's last op was a read, so write wins, then read
        arvalid = 2'b01; awvalid = 2'b01; arlen = '0; awlen = '0;
        araddr[31:0] = 32'h5000; awaddr[31:0] = 32'h5800; settle();
        chk("tg_awready", awready, 2'b01);
        chk("tg_arready", arready, 2'b00);
        tick(); awvalid = '0; settle();
        chk("tg_req_addr_w", mem_req_addr, 32'h5800);
        tick(); wvalid = 2'b01; wdata[63:0] = 64'h55; wlast = 2'b01; settle();
        chk("tg_wr_valid", mem_wr_valid, 1);
        tick(); wvalid = '0; wlast = '0; settle();
        chk("tg_bresp", bresp, 2'b00);
        bready = 2'b01; tick(); bready = '0; awvalid = 2'b01; settle();
        chk("tg_arready2", arready, 2'b01);
        chk("tg_awready2", awready, 2'b00);
        tick(); arvalid = '0; awvalid = '0; settle();
        chk("tg_req_op_r", mem_req_opcode, 0);
        chk("tg_req_addr_r", mem_req_addr, 32'h5000);
        tick(); mem_rd_valid = 1'b1; rready = 2'b01; settle();
        chk("tg_rlast", rlast, 2'b01);
        tick(); mem_rd_valid = 1'b0; rready = '0;

        // Test 5: RREADY stall mid-burst
        arvalid = 2'b01; araddr[31:0] = 32'h6000; arlen[7:0] = 8'd3; settle();
        chk("t5_arready", arready, 2'b01);
        tick(); arvalid = '0; settle();
        chk("t5_req_len", mem_req_len, 3);
        tick(); mem_rd_valid = 1'b1; rready = 2'b01; mem_rd_bits = 64'hF0; settle();
        chk("t5_rlast0", rlast, 2'b00);
        tick(); rready = 2'b00; mem_rd_bits = 64'hF1;
        for (int s = 0; s < 3; s++) begin
            settle();
            chk("t5_stall_rd_ready", mem_rd_ready, 0);
            chk("t5_stall_rvalid", rvalid, 2'b01);
            chk("t5_stall_rlast", rlast, 2'b00);
            tick();
        end
        rready = 2'b01;
        for (int b = 1; b < 4; b++) begin
            mem_rd_bits = 64'hF0 + 64'(b); settle();
            chk("t5_rdata", rdata, 64'hF0 + 64'(b));
            chk("t5_rlast", rlast, (b == 3) ? 2'b01 : 2'b00);
            chk("t5_rd_ready", mem_rd_ready, 1);
            tick();
        end
        mem_rd_valid = 1'b0; rready = '0; settle();
        chk("t5_idle", dbg_state, 0);

        // Test 6: reset during beat 2 of a ch0 read; ch1 waits and is served after release
        arvalid = 2'b01; araddr[31:0] = 32'h7000; arlen[7:0] = 8'd3; settle();
        tick(); arvalid = 2'b10; araddr[63:32] = 32'h7100; arlen[15:8] = 8'd5;
        tick(); mem_rd_valid = 1'b1; rready = 2'b01;
        for (int b = 0; b < 2; b++) begin
            mem_rd_bits = 64'h70 + 64'(b); tick();
        end
        mem_rd_bits = 64'h72; settle();
        chk("t6_pre_rvalid", rvalid, 2'b01);
        ap_rst_n = 1'b0; settle();
        chk("t6_rst_rvalid", rvalid, 2'b00);
        chk("t6_rst_rlast", rlast, 2'b00);
        chk("t6_rst_rd_ready", mem_rd_ready, 0);
        chk("t6_rst_rdata", rdata, 0);
        chk("t6_rst_arready", arready, 2'b00);
        chk("t6_rst_state", dbg_state, 0);
        tick(); mem_rd_valid = 1'b0; rready = '0; ap_rst_n = 1'b1; settle();
        chk("t6_arready_ch1", arready, 2'b10);
        tick(); arvalid = '0; settle();
        chk("t6_req_valid", mem_req_valid, 1);
        chk("t6_req_len", mem_req_len, 5);
        chk("t6_req_addr", mem_req_addr, 32'h7100);
        tick(); mem_rd_valid = 1'b1; rready = 2'b10;
        for (int b = 0; b < 6; b++) begin
            settle();
            chk("t6_rlast", rlast, (b == 5) ? 2'b10 : 2'b00);
            tick();
        end
        mem_rd_valid = 1'b0; rready = '0; settle();
        chk("t6_idle", dbg_state, 0);
        chk("t6_bvalid", bvalid, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
